// File: rtl/mem_access_stage.sv
// mem_access_stage: RV64 MEM stage issuing loads/stores on a valid/ready data bus and producing the MEM/WB slot
// Ports: EX/MEM slot (in_valid, flush_MEM, mem_ren/wen/size/unsigned, alu_result_MEM, store_data_MEM, rd_MEM, reg_wen_MEM),
//        stall_MEM to upstream, dmem_* request/response bus, out_* registered MEM/WB slot with misalign flag.
module mem_access_stage #(
  parameter int XLEN = 64,
  parameter int REG_ID_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                flush_MEM,
  input  logic                mem_ren,
  input  logic                mem_wen,
  input  logic [1:0]          mem_size,
  input  logic                mem_unsigned,
  input  logic [XLEN-1:0]     alu_result_MEM,
  input  logic [XLEN-1:0]     store_data_MEM,
  input  logic [REG_ID_W-1:0] rd_MEM,
  input  logic                reg_wen_MEM,
  output logic                stall_MEM,
  output logic                dmem_req_valid,
  input  logic                dmem_req_ready,
  output logic [XLEN-1:0]     dmem_addr,
  output logic                dmem_we,
  output logic [XLEN-1:0]     dmem_wdata,
  output logic [7:0]          dmem_wmask,
  input  logic                dmem_resp_valid,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic                out_valid,
  output logic [XLEN-1:0]     out_wb_data,
  output logic [REG_ID_W-1:0] out_rd,
  output logic                out_reg_wen,
  output logic                out_misalign
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nx;
  logic ev, is_mem, mis, done, idle;
  logic [2:0] off;
  logic [7:0] bmask;
  logic [XLEN-1:0] sh, ld;
  assign ev = in_valid & ~flush_MEM;
  assign is_mem = mem_ren | mem_wen;
  assign off = alu_result_MEM[2:0];
  // low mem_size bits of the offset must be zero; size 3 wraps to mask 3'b111
  assign mis = is_mem & |(off & ((3'(1) << mem_size) - 3'(1)));
  assign idle = state == IDLE;
  assign done = (state == WAIT) & dmem_resp_valid;
  assign stall_MEM = ev & is_mem & ~mis & ~done;
  assign dmem_req_valid = state == REQ;
  assign dmem_addr = {alu_result_MEM[XLEN-1:3], 3'b0};
  assign dmem_we = mem_wen;
  assign dmem_wdata = store_data_MEM << {off, 3'b0};
  assign bmask = mem_size == 2'd0 ? 8'h01 : mem_size == 2'd1 ? 8'h03 : mem_size == 2'd2 ? 8'h0F : 8'hFF;
  assign dmem_wmask = bmask << off;
  assign sh = dmem_rdata >> {off, 3'b0};
  always_comb begin
    ld = mem_size == 2'd0 ? {{(XLEN-8){~mem_unsigned & sh[7]}}, sh[7:0]} :
         mem_size == 2'd1 ? {{(XLEN-16){~mem_unsigned & sh[15]}}, sh[15:0]} :
         mem_size == 2'd2 ? {{(XLEN-32){~mem_unsigned & sh[31]}}, sh[31:0]} : sh;
    state_nx = idle ? ((ev & is_mem & ~mis) ? REQ : IDLE) :
               state == REQ ? (dmem_req_ready ? WAIT : REQ) :
               (dmem_resp_valid ? IDLE : WAIT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_wb_data <= '0;
      out_rd <= '0;
      out_reg_wen <= 1'b0;
      out_misalign <= 1'b0;
    end else begin
      state <= state_nx;
      out_valid <= (idle & ev & (~is_mem | mis)) | done;
      out_reg_wen <= (idle & ev & ~is_mem) ? reg_wen_MEM : done & reg_wen_MEM & mem_ren;
      out_misalign <= idle & ev & mis;
      // data fields only move when a slot is produced; otherwise they keep stale values
      if ((idle & ev & (~is_mem | mis)) | done) begin
        out_rd <= rd_MEM;
        out_wb_data <= done ? (mem_ren ? ld : '0) : alu_result_MEM;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage
module tb_mem_access_stage;
  logic clk = 0, rst = 1;
  logic in_valid = 0, flush_MEM = 0, mem_ren = 0, mem_wen = 0, mem_unsigned = 0, reg_wen_MEM = 0;
  logic [1:0] mem_size = 0;
  logic [63:0] alu_result_MEM = 0, store_data_MEM = 0, dmem_rdata = 0;
  logic [4:0] rd_MEM = 0;
  logic dmem_req_ready = 0, dmem_resp_valid = 0;
  logic stall_MEM, dmem_req_valid, dmem_we, out_valid, out_reg_wen, out_misalign;
  logic [63:0] dmem_addr, dmem_wdata, out_wb_data;
  logic [7:0] dmem_wmask;
  logic [4:0] out_rd;
  typedef struct {
    logic [63:0] wb;
    logic [4:0] rd;
    logic wen;
    logic mis;
    logic cmp_wb;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_pass = 0;
  logic [4:0] next_rd = 5'd1;
  mem_access_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush_MEM(flush_MEM),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .alu_result_MEM(alu_result_MEM), .store_data_MEM(store_data_MEM), .rd_MEM(rd_MEM),
    .reg_wen_MEM(reg_wen_MEM), .stall_MEM(stall_MEM), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_resp_valid(dmem_resp_valid),
    .dmem_rdata(dmem_rdata), .out_valid(out_valid), .out_wb_data(out_wb_data),
    .out_rd(out_rd), .out_reg_wen(out_reg_wen), .out_misalign(out_misalign)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      else begin
        e = sb.pop_front();
        chk("out_rd", 64'(out_rd), 64'(e.rd));
        chk("out_reg_wen", 64'(out_reg_wen), 64'(e.wen));
        chk("out_misalign", 64'(out_misalign), 64'(e.mis));
        if (e.cmp_wb) chk("out_wb_data", out_wb_data, e.wb);
      end
    end
  end
  task automatic drive(input logic ren, input logic wen, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] sdata);
    in_valid = 1;
    flush_MEM = 0;
    mem_ren = ren;
    mem_wen = wen;
    mem_size = size;
    mem_unsigned = uns;
    alu_result_MEM = addr;
    store_data_MEM = sdata;
    rd_MEM = next_rd;
    reg_wen_MEM = 1;
    next_rd = next_rd + 5'd1;
  endtask
  task automatic bubble();
    in_valid = 0;
    mem_ren = 0;
    mem_wen = 0;
  endtask
  task automatic alu_op(input logic [63:0] val, input logic [4:0] rd, input logic rwen);
    drive(0, 0, 2'd0, 0, val, 64'd0);
    rd_MEM = rd;
    reg_wen_MEM = rwen;
    sb.push_back('{val, rd, rwen, 1'b0, 1'b1});
    @(negedge clk);
    chk("alu_stall", 64'(stall_MEM), 64'd0);
    chk("alu_req_valid", 64'(dmem_req_valid), 64'd0);
    step();
  endtask
  task automatic mis_op(input logic ren, input logic wen, input logic [1:0] size, input logic [63:0] addr);
    drive(ren, wen, size, 0, addr, 64'd0);
    sb.push_back('{64'd0, rd_MEM, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    chk("mis_stall", 64'(stall_MEM), 64'd0);
    chk("mis_req_valid0", 64'(dmem_req_valid), 64'd0);
    step();
    bubble();
    @(negedge clk);
    chk("mis_req_valid1", 64'(dmem_req_valid), 64'd0);
    step();
  endtask
  task automatic mem_op(input logic ren, input logic wen, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] sdata, input logic [63:0] rdata,
                        input int rdy_dly, input int rsp_dly, input logic [63:0] exp_addr,
                        input logic [63:0] exp_wb, input logic [63:0] exp_wdata, input logic [7:0] exp_mask);
    drive(ren, wen, size, uns, addr, sdata);
    sb.push_back('{exp_wb, rd_MEM, ren, 1'b0, 1'b1});
    @(negedge clk);
    chk("idle_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("idle_stall", 64'(stall_MEM), 64'd1);
    step();
    for (int i = 0; i <= rdy_dly; i++) begin
      dmem_req_ready = (i == rdy_dly);
      @(negedge clk);
      chk("req_valid", 64'(dmem_req_valid), 64'd1);
      chk("req_addr", dmem_addr, exp_addr);
      chk("req_we", 64'(dmem_we), 64'(wen));
      chk("req_wmask", 64'(dmem_wmask), 64'(exp_mask));
      if (wen) chk("req_wdata", dmem_wdata, exp_wdata);
      chk("req_stall", 64'(stall_MEM), 64'd1);
      step();
    end
    dmem_req_ready = 0;
    for (int i = 0; i <= rsp_dly; i++) begin
      dmem_resp_valid = (i == rsp_dly);
      dmem_rdata = (i == rsp_dly) ? rdata : 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      chk("wait_req_valid", 64'(dmem_req_valid), 64'd0);
      chk("wait_stall", 64'(stall_MEM), 64'(i != rsp_dly));
      step();
    end
    dmem_resp_valid = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_wb_data", out_wb_data, 64'd0);
    chk("rst_rd", 64'(out_rd), 64'd0);
    chk("rst_reg_wen", 64'(out_reg_wen), 64'd0);
    chk("rst_misalign", 64'(out_misalign), 64'd0);
    chk("rst_req_valid", 64'(dmem_req_valid), 64'd0);
    step();
    step();
    rst = 0;
    drive(1, 0, 2'd3, 0, 64'h10, 64'd0);
    step();
    dmem_req_ready = 1;
    step();
    dmem_req_ready = 0;
    #2;
    rst = 1;
    bubble();
    #1;
    chk("midrst_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_wb_data", out_wb_data, 64'd0);
    step();
    rst = 0;
    dmem_resp_valid = 1;
    dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("stray_req_valid", 64'(dmem_req_valid), 64'd0);
    step();
    dmem_resp_valid = 0;
    @(negedge clk);
    chk("stray_out_valid", 64'(out_valid), 64'd0);
    step();
    alu_op(64'h1234, 5'd5, 1'b1);
    bubble();
    step();
    mem_op(1, 0, 2'd0, 0, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 2, 2,
           64'h1000, 64'hFFFF_FFFF_FFFF_FF80, 64'd0, 8'h08);
    mem_op(1, 0, 2'd0, 1, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 2, 2,
           64'h1000, 64'h80, 64'd0, 8'h08);
    mem_op(0, 1, 2'd1, 0, 64'h2006, 64'hBEEF, 64'd0, 0, 0,
           64'h2000, 64'd0, 64'hBEEF_0000_0000_0000, 8'hC0);
    bubble();
    step();
    mis_op(1, 0, 2'd2, 64'h3002);
    mis_op(0, 1, 2'd3, 64'h3004);
    mem_op(1, 0, 2'd3, 0, 64'h4000, 64'd0, 64'h0123_4567_89AB_CDEF, 3, 0,
           64'h4000, 64'h0123_4567_89AB_CDEF, 64'd0, 8'hFF);
    mem_op(1, 0, 2'd3, 0, 64'h4008, 64'd0, 64'hFEDC_BA98_7654_3210, 0, 1,
           64'h4008, 64'hFEDC_BA98_7654_3210, 64'd0, 8'hFF);
    mem_op(1, 0, 2'd2, 0, 64'h5004, 64'd0, 64'h89AB_CDEF_0000_0000, 1, 0,
           64'h5000, 64'hFFFF_FFFF_89AB_CDEF, 64'd0, 8'hF0);
    mem_op(1, 0, 2'd1, 1, 64'h5002, 64'd0, 64'h0000_0000_ABCD_0000, 0, 0,
           64'h5000, 64'h0000_0000_0000_ABCD, 64'd0, 8'h0C);
    mem_op(0, 1, 2'd3, 0, 64'h6000, 64'h1122_3344_5566_7788, 64'd0, 0, 0,
           64'h6000, 64'd0, 64'h1122_3344_5566_7788, 8'hFF);
    alu_op(64'hCAFE, 5'd9, 1'b0);
    drive(1, 0, 2'd3, 0, 64'h7000, 64'd0);
    flush_MEM = 1;
    @(negedge clk);
    chk("flush_stall", 64'(stall_MEM), 64'd0);
    step();
    @(negedge clk);
    chk("flush_req_valid", 64'(dmem_req_valid), 64'd0);
    bubble();
    flush_MEM = 0;
    repeat (3) step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
